alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Command-issue and result-capture stage that sits directly around the 8-bit ALU. It accepts operation commands over a valid/ready stream, buffers them in a small FIFO, and drives the ALU operand/select inputs from the FIFO head. It registers the ALU result with divide-by-zero and carry qualification, and presents it downstream over a second valid/ready stream.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid & in_ready
- in_a  input  8  operand A
- in_b  input  8  operand B
- in_sel  input  4  ALU opcode
- alu_a  output  8  to ALU A
- alu_b  output  8  to ALU B
- alu_sel  output  4  to ALU select
- alu_out  input  8  from ALU result
- alu_carry  input  1  from ALU carry-out (carry of A+B)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_result  output  8  registered result
- out_carry  output  1  carry flag, meaningful for ADD only
- out_divz  output  1  divide-by-zero flag
- level  output  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Push: on in_valid & in_ready, {in_sel, in_a, in_b} is written at the tail. in_ready = (level != DEPTH); it has no combinational dependence on out_ready.
- Head drive: while level > 0, alu_a/alu_b/alu_sel equal the head entry's fields, taken from registers with no combinational path from in_*. While empty, all three are driven to 0.
- Issue/capture: fire = (level > 0) & (~out_valid | out_ready). On fire, the head is popped and the output register loads:
  - out_result = 8'hFF and out_divz = 1 if head sel == DIV (4'b0011) and head b == 0; otherwise out_result = alu_out and out_divz = 0.
  - out_carry = alu_carry if head sel == ADD (4'b0000), else 0.
  - out_valid = 1.
- Output drain: on out_valid & out_ready with no fire, out_valid clears. out_result, out_carry and out_divz hold their last values.
- Simultaneous push and pop: both occur and level is unchanged. Push when full is impossible because in_ready = 0. Pop when empty is impossible by definition of fire.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- Backpressure: while out_valid & ~out_ready, the output register is frozen and nothing pops. The FIFO fills, and in_ready drops when level == DEPTH.
- Reset: level = 0, pointers = 0, out_valid = 0, out_result = 0, out_carry = 0, out_divz = 0. alu_* = 0 because the FIFO is empty. in_ready = 1 from the first post-reset cycle.
  - Pushes during rst are discarded.
  - Reset mid-operation drops all queued commands and any pending result without emitting it.

## Timing
- Latency: command accepted at edge N appears on alu_* after edge N; the result is captured at edge N+1; out_valid is high from edge N+1. That is 2 cycles from accept to valid with the pipeline empty.
- Throughput: one result per cycle with out_ready held high.
- FIFO storage contents are not reset. Only pointers and level are reset.
- ALU is combinational; the capture path is head register → ALU → output register in one cycle.

## Structure
- Shared package alu_pkg:
  - opcode localparams ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_MUL=4'b0010, ALU_DIV=4'b0011, through ALU_EQ=4'b1111
  - DIVZ_RESULT=8'hFF
  - packed command typedef alu_cmd_t {sel[3:0], a[7:0], b[7:0]}
- One sub-module, alu_cmd_fifo: synchronous FIFO of alu_cmd_t with push/pop/level and registered head output.
- The ALU is instantiated alongside at the parent level, not inside this block.

## Test plan
- Single ADD: push A=8'hF0, B=8'h20, sel=0000 into an idle block with out_ready=1 → out_valid 2 cycles after accept, out_result=8'h10, out_carry=1, out_divz=0.
- Divide by zero: push A=8'h40, B=0, sel=0011 → out_result=8'hFF, out_divz=1, out_carry=0. Then push A=8'h40, B=8'h04, sel=0011 → out_result=8'h10, out_divz=0.
- Carry masking: push A=8'hFF, B=8'h01, sel=0001 (SUB) → out_result=8'hFE, out_carry=0 even though alu_carry=1.
- Backpressure/full (DEPTH=4): out_ready=0, push 6 commands back-to-back → 1 result held, level=4, in_ready=0 after the 5th accept, the 6th is stalled. Raise out_ready → 5 results drain in order, one per cycle.
- Streaming: out_ready=1, push 8 ops on consecutive cycles, including simultaneous push/pop → 8 results on consecutive cycles, in order, with level never above 1.
- Reset mid-operation: 3 queued plus 1 valid result, assert rst for 1 cycle → out_valid=0, level=0, alu_*=0, in_ready=1, and no queued result is ever emitted.

Source files
------------

// File: rtl/alu_issue_queue_pkg.sv
// Shared opcode encodings, command record and result-qualification helpers
// for the ALU issue/capture stage.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOT  = 4'b0111;
    localparam logic [3:0] ALU_SHL  = 4'b1000;
    localparam logic [3:0] ALU_SHR  = 4'b1001;
    localparam logic [3:0] ALU_ROL  = 4'b1010;
    localparam logic [3:0] ALU_ROR  = 4'b1011;
    localparam logic [3:0] ALU_NAND = 4'b1100;
    localparam logic [3:0] ALU_NOR  = 4'b1101;
    localparam logic [3:0] ALU_GT   = 4'b1110;
    localparam logic [3:0] ALU_EQ   = 4'b1111;

    localparam logic [7:0] DIVZ_RESULT = 8'hFF;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

    function automatic logic is_div_zero(input alu_cmd_t cmd);
        return (cmd.sel == ALU_DIV) && (cmd.b == 8'h00);
    endfunction

    // Carry is only architecturally meaningful for ADD; mask it elsewhere.
    function automatic logic qualify_carry(input alu_cmd_t cmd, input logic carry);
        return (cmd.sel == ALU_ADD) ? carry : 1'b0;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Command stream, ALU drive/return and result stream of the issue queue,
// bundled with the queue occupancy.
interface alu_issue_queue_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [3:0]       in_sel;

    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [3:0]       alu_sel;
    logic [7:0]       alu_out;
    logic             alu_carry;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_result;
    logic             out_carry;
    logic             out_divz;

    logic [LVL_W-1:0] level;

    modport slave (
        input  in_valid, in_a, in_b, in_sel,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_out, alu_carry,
        output out_valid, out_result, out_carry, out_divz,
        input  out_ready,
        output level
    );

    modport master (
        output in_valid, in_a, in_b, in_sel,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_out, alu_carry,
        input  out_valid, out_result, out_carry, out_divz,
        output out_ready,
        input  level
    );

endinterface

// File: rtl/alu_issue_queue_cmd_fifo.sv
// Synchronous command FIFO; head is a register-only mux that reads as zero
// while empty. Storage is deliberately not reset.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  alu_cmd_t                     i_push_data,
    input  logic                         i_pop,
    output alu_cmd_t                     o_head,
    output logic                         o_empty,
    output logic                         o_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    alu_cmd_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == LVL_W'(0));
    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_level   = r_level;
    assign w_do_push = i_push & ~o_full & ~i_rst;
    assign w_do_pop  = i_pop & ~o_empty;

    // Command storage write.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_level  <= LVL_W'(0);
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Head view, forced to zero while empty.
    always_comb begin
        o_head = '{sel: 4'h0, a: 8'h00, b: 8'h00};
        if (!o_empty) begin
            o_head = r_mem[r_rd_ptr];
        end else begin
            o_head = '{sel: 4'h0, a: 8'h00, b: 8'h00};
        end
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Issue stage around a combinational 8-bit ALU: queues commands, drives the
// ALU from the queue head and captures a qualified result for downstream.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_queue_if.slave  bus
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    alu_cmd_t         w_push_cmd;
    alu_cmd_t         w_head;
    logic             w_empty;
    logic             w_full;
    logic             w_in_ready;
    logic             w_fire;
    logic [LVL_W-1:0] w_level;

    logic             r_out_valid;
    logic [7:0]       r_out_result;
    logic             r_out_carry;
    logic             r_out_divz;

    assign w_push_cmd = '{sel: bus.in_sel, a: bus.in_a, b: bus.in_b};
    assign w_in_ready = ~w_full;
    // Issue whenever a command waits and the output slot is free or draining.
    assign w_fire     = ~w_empty & (~r_out_valid | bus.out_ready);

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (bus.in_valid & w_in_ready),
        .i_push_data (w_push_cmd),
        .i_pop       (w_fire),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_level     (w_level)
    );

    // Result capture register with divide-by-zero override and carry masking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= 8'h00;
            r_out_carry  <= 1'b0;
            r_out_divz   <= 1'b0;
        end else if (w_fire) begin
            r_out_valid  <= 1'b1;
            r_out_result <= is_div_zero(w_head) ? DIVZ_RESULT : bus.alu_out;
            r_out_carry  <= qualify_carry(w_head, bus.alu_carry);
            r_out_divz   <= is_div_zero(w_head);
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid  <= r_out_valid;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.alu_a      = w_head.a;
    assign bus.alu_b      = w_head.b;
    assign bus.alu_sel    = w_head.sel;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_carry  = r_out_carry;
    assign bus.out_divz   = r_out_divz;
    assign bus.level      = w_level;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: a vector table of single commands plus
// hand-written backpressure, streaming and mid-operation reset sequences.
module tb_alu_issue_queue;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    alu_issue_queue_if #(.DEPTH(4)) u_if ();

    alu_issue_queue #(.DEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; carry is always the carry-out of A+B.
    logic [8:0] w_sum;
    assign w_sum = {1'b0, u_if.alu_a} + {1'b0, u_if.alu_b};
    assign u_if.alu_carry = w_sum[8];
    always_comb begin
        case (u_if.alu_sel)
            ALU_ADD: u_if.alu_out = w_sum[7:0];
            ALU_SUB: u_if.alu_out = u_if.alu_a - u_if.alu_b;
            ALU_MUL: u_if.alu_out = u_if.alu_a * u_if.alu_b;
            ALU_DIV: u_if.alu_out = (u_if.alu_b == 8'h00) ? 8'h00 : u_if.alu_a / u_if.alu_b;
            ALU_AND: u_if.alu_out = u_if.alu_a & u_if.alu_b;
            ALU_XOR: u_if.alu_out = u_if.alu_a ^ u_if.alu_b;
            default: u_if.alu_out = 8'h00;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] res;
        logic       carry;
        logic       divz;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        u_if.in_valid = v;
        u_if.in_a     = a;
        u_if.in_b     = b;
        u_if.in_sel   = s;
    endtask

    logic [7:0] exp_res [8];
    logic       exp_c   [8];
    logic [8:0] tmp;

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0] = '{a: 8'hF0, b: 8'h20, sel: 4'b0000, res: 8'h10, carry: 1'b1, divz: 1'b0};
        vecs[1] = '{a: 8'h40, b: 8'h00, sel: 4'b0011, res: 8'hFF, carry: 1'b0, divz: 1'b1};
        vecs[2] = '{a: 8'h40, b: 8'h04, sel: 4'b0011, res: 8'h10, carry: 1'b0, divz: 1'b0};
        vecs[3] = '{a: 8'hFF, b: 8'h01, sel: 4'b0001, res: 8'hFE, carry: 1'b0, divz: 1'b0};
        vecs[4] = '{a: 8'h7F, b: 8'h01, sel: 4'b0000, res: 8'h80, carry: 1'b0, divz: 1'b0};
        vecs[5] = '{a: 8'h03, b: 8'h05, sel: 4'b0010, res: 8'h0F, carry: 1'b0, divz: 1'b0};
        vecs[6] = '{a: 8'hAA, b: 8'h0F, sel: 4'b0110, res: 8'hA5, carry: 1'b0, divz: 1'b0};
        vecs[7] = '{a: 8'h00, b: 8'h00, sel: 4'b0011, res: 8'hFF, carry: 1'b0, divz: 1'b1};
        vecs[8] = '{a: 8'hFF, b: 8'hFF, sel: 4'b0000, res: 8'hFE, carry: 1'b1, divz: 1'b0};

        // Power-on reset with a push attempt that must be discarded.
        rst = 1'b1;
        u_if.out_ready = 1'b0;
        drive(1'b1, 8'h12, 8'h34, 4'b0000);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'b0000);
        chk("rst_level", u_if.level, 3'd0);
        chk("rst_out_valid", u_if.out_valid, 1'b0);
        chk("rst_out_result", u_if.out_result, 8'h00);
        chk("rst_out_carry", u_if.out_carry, 1'b0);
        chk("rst_out_divz", u_if.out_divz, 1'b0);
        chk("rst_alu_a", u_if.alu_a, 8'h00);
        chk("rst_alu_b", u_if.alu_b, 8'h00);
        chk("rst_alu_sel", u_if.alu_sel, 4'h0);
        chk("rst_in_ready", u_if.in_ready, 1'b1);
        tick();
        chk("rst_push_dropped", u_if.level, 3'd0);

        // Single commands into an idle block.
        u_if.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel);
            chk("vec_in_ready", u_if.in_ready, 1'b1);
            tick();
            drive(1'b0, 8'h00, 8'h00, 4'b0000);
            chk("vec_head_a", u_if.alu_a, vecs[i].a);
            chk("vec_head_b", u_if.alu_b, vecs[i].b);
            chk("vec_head_sel", u_if.alu_sel, vecs[i].sel);
            chk("vec_early_valid", u_if.out_valid, 1'b0);
            tick();
            chk("vec_valid", u_if.out_valid, 1'b1);
            chk("vec_result", u_if.out_result, vecs[i].res);
            chk("vec_carry", u_if.out_carry, vecs[i].carry);
            chk("vec_divz", u_if.out_divz, vecs[i].divz);
            chk("vec_level", u_if.level, 3'd0);
            tick();
            chk("vec_drained", u_if.out_valid, 1'b0);
            chk("vec_hold_result", u_if.out_result, vecs[i].res);
        end

        // Backpressure: 5 accepted (1 held + 4 queued), 6th stalls.
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i), 8'h10, ALU_ADD);
            chk("bp_in_ready", u_if.in_ready, 1'b1);
            tick();
        end
        drive(1'b1, 8'h05, 8'h10, ALU_ADD);
        chk("bp_full_ready", u_if.in_ready, 1'b0);
        chk("bp_full_level", u_if.level, 3'd4);
        chk("bp_held_valid", u_if.out_valid, 1'b1);
        chk("bp_held_result", u_if.out_result, 8'h10);
        tick();
        chk("bp_stall_ready", u_if.in_ready, 1'b0);
        chk("bp_stall_level", u_if.level, 3'd4);
        chk("bp_stall_result", u_if.out_result, 8'h10);
        drive(1'b0, 8'h00, 8'h00, 4'b0000);
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_drain_valid", u_if.out_valid, 1'b1);
            chk("bp_drain_result", u_if.out_result, 8'h10 + 8'(k));
            tick();
        end
        chk("bp_end_valid", u_if.out_valid, 1'b0);
        chk("bp_end_level", u_if.level, 3'd0);

        // Streaming: one push per cycle, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            tmp = {1'b0, 8'(i * 33)} + 9'h040;
            exp_res[i] = tmp[7:0];
            exp_c[i]   = tmp[8];
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(i * 33), 8'h40, ALU_ADD);
            tick();
            chk("st_level", u_if.level, 3'd1);
            if (i > 0) begin
                chk("st_valid", u_if.out_valid, 1'b1);
                chk("st_result", u_if.out_result, exp_res[i-1]);
                chk("st_carry", u_if.out_carry, exp_c[i-1]);
            end else begin
                chk("st_first_valid", u_if.out_valid, 1'b0);
            end
        end
        drive(1'b0, 8'h00, 8'h00, 4'b0000);
        tick();
        chk("st_last_valid", u_if.out_valid, 1'b1);
        chk("st_last_result", u_if.out_result, exp_res[7]);
        chk("st_last_carry", u_if.out_carry, exp_c[7]);
        chk("st_last_level", u_if.level, 3'd0);
        tick();
        chk("st_idle_valid", u_if.out_valid, 1'b0);

        // Reset mid-operation: 1 pending result and 3 queued are dropped.
        u_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h50 + 8'(i), 8'h01, ALU_ADD);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 4'b0000);
        chk("mr_pre_level", u_if.level, 3'd3);
        chk("mr_pre_valid", u_if.out_valid, 1'b1);
        rst = 1'b1;
        drive(1'b1, 8'h77, 8'h01, ALU_ADD);
        tick();
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 4'b0000);
        chk("mr_valid", u_if.out_valid, 1'b0);
        chk("mr_level", u_if.level, 3'd0);
        chk("mr_alu_a", u_if.alu_a, 8'h00);
        chk("mr_alu_b", u_if.alu_b, 8'h00);
        chk("mr_alu_sel", u_if.alu_sel, 4'h0);
        chk("mr_in_ready", u_if.in_ready, 1'b1);
        chk("mr_result", u_if.out_result, 8'h00);
        u_if.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mr_no_emit", u_if.out_valid, 1'b0);
            chk("mr_no_level", u_if.level, 3'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
